// File: rtl/muldiv_issue_arbiter.sv
// Two-lane issue arbiter for a shared iterative multiply/divide unit.
// Define MULDIV_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed lane-0 priority.
module muldiv_issue_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [5:0]            funct0,
  input  logic [DATA_W-1:0]     a0,
  input  logic [DATA_W-1:0]     b0,
  input  logic                  flush0,
  input  logic                  req1,
  input  logic [5:0]            funct1,
  input  logic [DATA_W-1:0]     a1,
  input  logic [DATA_W-1:0]     b1,
  input  logic                  flush1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [2*DATA_W-1:0]   rsp_data0,
  output logic [2*DATA_W-1:0]   rsp_data1,
  output logic                  rsp_err0,
  output logic                  rsp_err1,
  output logic                  unit_start,
  output logic [1:0]            unit_op,
  output logic [DATA_W-1:0]     unit_a,
  output logic [DATA_W-1:0]     unit_b,
  input  logic                  unit_done,
  input  logic [2*DATA_W-1:0]   unit_result,
  output logic                  busy
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                kill_q, kill_d;
  logic [2*DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                err0_q, err0_d, err1_q, err1_d;

  logic                elig0, elig1, any_elig, pick1;
  logic [5:0]          sel_funct;
  logic                sel_valid, own_flush, rsp_fire;
  logic                cap_en, cap_lane, cap_err;
  logic [2*DATA_W-1:0] cap_data;

  assign elig0    = req0 & ~flush0;
  assign elig1    = req1 & ~flush1;
  assign any_elig = elig0 | elig1;

`ifdef MULDIV_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // last_q = 1 means lane 1 was granted last, so lane 0 wins the next tie.
  assign pick1  = elig1 & (~elig0 | ~last_q);
  assign last_d = (state_q == S_IDLE && any_elig) ? pick1 : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign pick1 = elig1 & ~elig0;
`endif

  assign sel_funct = pick1 ? funct1 : funct0;
  assign sel_valid = (sel_funct[5:2] == 4'b0110);
  assign own_flush = owner_q ? flush1 : flush0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    cap_en   = 1'b0;
    cap_lane = owner_q;
    cap_data = '0;
    cap_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          owner_d = pick1;
          op_d    = sel_funct[1:0];
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          if (sel_valid) begin
            state_d = S_START;
          end else begin
            state_d  = S_RESP;
            cap_en   = 1'b1;
            cap_lane = pick1;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
        if (own_flush) kill_d = 1'b1;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (own_flush) kill_d = 1'b1;
        // done has priority over a timeout expiring in the same cycle
        if (unit_done) begin
          state_d  = S_RESP;
          cap_en   = 1'b1;
          cap_data = unit_result;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_RESP;
          cap_en   = 1'b1;
          cap_data = '1;
          cap_err  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data0_d = data0_q;
    err0_d  = err0_q;
    data1_d = data1_q;
    err1_d  = err1_q;
    if (cap_en) begin
      if (cap_lane) begin
        data1_d = cap_data;
        err1_d  = cap_err;
      end else begin
        data0_d = cap_data;
        err0_d  = cap_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  // Grants are combinational, so gate them with reset to keep outputs quiet during reset.
  assign gnt0       = rst_n & (state_q == S_IDLE) & any_elig & ~pick1;
  assign gnt1       = rst_n & (state_q == S_IDLE) & pick1;
  assign rsp_fire   = (state_q == S_RESP) & ~kill_q & ~own_flush;
  assign rsp_valid0 = rsp_fire & ~owner_q;
  assign rsp_valid1 = rsp_fire & owner_q;
  assign rsp_data0  = data0_q;
  assign rsp_data1  = data1_q;
  assign rsp_err0   = err0_q;
  assign rsp_err1   = err1_q;
  assign unit_start = (state_q == S_START);
  assign unit_op    = op_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Self-checking bench for muldiv_issue_arbiter: directed scenarios plus randomized transactions.
`timescale 1ns/1ps
module tb_muldiv_issue_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, flush0, flush1;
  logic [5:0]    funct0, funct1;
  logic [31:0]   a0, b0, a1, b1;
  logic          gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
  logic [63:0]   rsp_data0, rsp_data1;
  logic          unit_start, unit_done, busy;
  logic [1:0]    unit_op;
  logic [31:0]   unit_a, unit_b;
  logic [63:0]   unit_result;

  int n_checks  = 0;
  int n_fail    = 0;
  int last_lane = 1;

  muldiv_issue_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .funct0(funct0), .a0(a0), .b0(b0), .flush0(flush0),
    .req1(req1), .funct1(funct1), .a1(a1), .b1(b1), .flush1(flush1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each op; HI holds remainder and LO quotient for divides.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      6'h18:   return sa * sb;
      6'h19:   return ua * ub;
      6'h1A:   return {32'(sa % sb), 32'(sa / sb)};
      6'h1B:   return {32'(ua % ub), 32'(ua / ub)};
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit is_valid(input logic [5:0] f);
    return (f == 6'h18) || (f == 6'h19) || (f == 6'h1A) || (f == 6'h1B);
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] f;
    if ($urandom_range(0, 7) == 0) begin
      f = 6'($urandom);
      if (is_valid(f)) f = 6'h20;
    end else begin
      f = 6'h18 + 6'($urandom_range(0, 3));
    end
    return f;
  endfunction

  function automatic int model_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef MULDIV_ARB_ROUND_ROBIN_EN
      return (last_lane == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  // One complete transaction; d = WAIT cycle index carrying unit_done (>= TO means never),
  // flush_at = WAIT cycle index to flush the owner, -2 = flush in RESP, -1 = none.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [5:0] f0, input logic [31:0] xa0, input logic [31:0] xb0,
                         input logic [5:0] f1, input logic [31:0] xa1, input logic [31:0] xb1,
                         input int d, input int flush_at);
    int          w;
    logic [5:0]  f;
    logic [31:0] xa, xb;
    logic [63:0] exp_data, rd_w;
    logic        exp_err, rv_w, rv_o, re_w;
    bit          killed, timed_out;
    w = model_winner(r0, r1);
    last_lane = w;
    f  = w ? f1 : f0;
    xa = w ? xa1 : xa0;
    xb = w ? xb1 : xb0;
    req0 = r0; funct0 = f0; a0 = xa0; b0 = xb0;
    req1 = r1; funct1 = f1; a1 = xa1; b1 = xb1;
    @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL grant: gnt1,gnt0=%b expected %b", {gnt1, gnt0}, (w ? 2'b10 : 2'b01));
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    killed = 0; timed_out = 0;
    exp_data = 64'h0; exp_err = 1'b0;
    if (is_valid(f)) begin
      @(negedge clk);
      n_checks++;
      if ({unit_start, unit_op, unit_a, unit_b} !== {1'b1, f[1:0], xa, xb}) begin
        n_fail++;
        $display("FAIL start: start,op,a,b=%b,%b,%h,%h expected 1,%b,%h,%h",
                 unit_start, unit_op, unit_a, unit_b, f[1:0], xa, xb);
      end
      @(posedge clk); #1;
      for (int k = 0; k < int'(TO); k++) begin
        if (k == flush_at) begin
          if (w == 1) flush1 = 1'b1; else flush0 = 1'b1;
          killed = 1;
        end
        if (k == d) begin
          unit_done = 1'b1;
          unit_result = ref_result({4'b0110, unit_op}, unit_a, unit_b);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, unit_start, rsp_valid0, rsp_valid1} !== 4'b1000) begin
          n_fail++;
          $display("FAIL wait_k%0d: busy,start,rv0,rv1=%b expected 1000", k,
                   {busy, unit_start, rsp_valid0, rsp_valid1});
        end
        @(posedge clk); #1;
        flush0 = 1'b0; flush1 = 1'b0; unit_done = 1'b0;
        if (k == d) break;
      end
      timed_out = (d > int'(TO) - 1);
      exp_data  = timed_out ? 64'hFFFF_FFFF_FFFF_FFFF : ref_result(f, xa, xb);
      exp_err   = timed_out;
    end
    if (flush_at == -2) begin
      if (w == 1) flush1 = 1'b1; else flush0 = 1'b1;
      killed = 1;
    end
    if (timed_out) begin
      unit_done = 1'b1;
      unit_result = 64'h0123_4567_89AB_CDEF;
    end
    @(negedge clk);
    rv_w = w ? rsp_valid1 : rsp_valid0;
    rv_o = w ? rsp_valid0 : rsp_valid1;
    rd_w = w ? rsp_data1 : rsp_data0;
    re_w = w ? rsp_err1 : rsp_err0;
    n_checks++;
    if ({rv_w, rv_o, busy, unit_start} !== {~killed, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL resp_valid: own,other,busy,start=%b expected %b",
               {rv_w, rv_o, busy, unit_start}, {~killed, 1'b0, 1'b1, 1'b0});
    end
    if (!killed) begin
      n_checks++;
      if ({rd_w, re_w} !== {exp_data, exp_err}) begin
        n_fail++;
        $display("FAIL resp_data lane%0d: data=%h err=%b expected data=%h err=%b",
                 w, rd_w, re_w, exp_data, exp_err);
      end
    end
    @(posedge clk); #1;
    flush0 = 1'b0; flush1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, rsp_valid0, rsp_valid1, gnt0, gnt1} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle: busy,rv0,rv1,g0,g1=%b expected 00000", {busy, rsp_valid0, rsp_valid1, gnt0, gnt1});
    end
    @(posedge clk); #1;
    if (timed_out) begin
      unit_done = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, rsp_valid0, rsp_valid1} !== 3'b0) begin
        n_fail++;
        $display("FAIL stray_done: busy,rv0,rv1=%b expected 000", {busy, rsp_valid0, rsp_valid1});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; flush0 = 0; flush1 = 0; funct0 = '0; funct1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; unit_done = 0; unit_result = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, unit_start, busy} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: flags=%b expected 00000000",
               {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, unit_start, busy});
    end
    n_checks++;
    if ({rsp_data0, rsp_data1, unit_op, unit_a, unit_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: d0=%h d1=%h op=%b a=%h b=%h expected all zero",
               rsp_data0, rsp_data1, unit_op, unit_a, unit_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_lane = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    run_txn(1'b1, 1'b0, 6'h18, 32'd7, 32'd6, 6'h00, 32'd0, 32'd0, 2, -1);
    n_checks++;
    if ({rsp_data1, rsp_err1, rsp_valid1} !== '0) begin
      n_fail++;
      $display("FAIL single_lane1: data1=%h err1=%b rv1=%b expected 0", rsp_data1, rsp_err1, rsp_valid1);
    end
  endtask

  task automatic test_tie();
    int          grants;
    int          w;
    logic [63:0] exp_div;
    exp_div = ref_result(6'h1A, 32'd100, 32'd7);
    req0 = 1; req1 = 1; funct0 = 6'h1A; funct1 = 6'h1A;
    a0 = 32'd100; b0 = 32'd7; a1 = 32'd100; b1 = 32'd7;
    unit_done = 1'b1; unit_result = exp_div;
    grants = 0;
    for (int cyc = 0; cyc < 80 && grants < 4; cyc++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        w = model_winner(req0, req1);
        last_lane = w;
        n_checks++;
        if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL tie_grant%0d: gnt1,gnt0=%b expected %b", grants, {gnt1, gnt0}, (w ? 2'b10 : 2'b01));
        end
        grants++;
      end
      if (rsp_valid0 || rsp_valid1) begin
        n_checks++;
        if ((rsp_valid0 ? rsp_data0 : rsp_data1) !== exp_div) begin
          n_fail++;
          $display("FAIL tie_data: data=%h expected %h", (rsp_valid0 ? rsp_data0 : rsp_data1), exp_div);
        end
      end
      @(posedge clk); #1;
      if (grants >= 3) req0 = 1'b0;
    end
    req1 = 1'b0;
    n_checks++;
    if (grants != 4) begin
      n_fail++;
      $display("FAIL tie_count: grants=%0d expected 4", grants);
    end
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge clk); #1;
    end
    unit_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_drain: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_invalid();
    run_txn(1'b0, 1'b1, 6'h00, 32'd0, 32'd0, 6'h20, 32'hDEAD_BEEF, 32'h1234_5678, 0, -1);
  endtask

  task automatic test_flush();
    req0 = 1; req1 = 1; flush0 = 1; funct0 = 6'h18; funct1 = 6'h2A;
    a0 = 32'd3; b0 = 32'd3; a1 = 32'd5; b1 = 32'd5;
    @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_mask: gnt1,gnt0=%b expected 10", {gnt1, gnt0});
    end
    last_lane = 1;
    @(posedge clk); #1;
    req0 = 0; req1 = 0; flush0 = 0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid1, rsp_valid0, rsp_data1, rsp_err1} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_mask_rsp: rv1=%b rv0=%b d1=%h e1=%b expected 1 0 0 0",
               rsp_valid1, rsp_valid0, rsp_data1, rsp_err1);
    end
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 6'h18, 32'd0, 32'd0, 6'h1B, 32'd12345, 32'd9, 3, 0);
    run_txn(1'b0, 1'b1, 6'h18, 32'd0, 32'd0, 6'h1B, 32'd1000, 32'd9, 1, -1);
    run_txn(1'b1, 1'b0, 6'h18, 32'd5, 32'd5, 6'h00, 32'd0, 32'd0, 0, -2);
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 6'h19, 32'hFFFF_0001, 32'd77, 6'h00, 32'd0, 32'd0, 100, -1);
    run_txn(1'b1, 1'b0, 6'h18, 32'hFFFF_FFFD, 32'd11, 6'h00, 32'd0, 32'd0, int'(TO) - 1, -1);
  endtask

  task automatic test_random();
    logic        r0, r1;
    logic [5:0]  f0, f1;
    logic [31:0] xa0, xb0, xa1, xb1;
    int          d, fl;
    for (int i = 0; i < 24; i++) begin
      r0  = 1'($urandom_range(0, 1));
      r1  = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      f0  = pick_funct();
      f1  = pick_funct();
      xa0 = $urandom; xb0 = $urandom; xa1 = $urandom; xb1 = $urandom;
      if (xb0 == 0) xb0 = 32'd1;
      if (xb1 == 0) xb1 = 32'd1;
      d = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0:       fl = -2;
        1:       fl = $urandom_range(0, (d < int'(TO) - 1) ? d : int'(TO) - 1);
        default: fl = -1;
      endcase
      run_txn(r0, r1, f0, xa0, xb0, f1, xa1, xb1, d, fl);
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1; funct0 = 6'h19; a0 = $urandom; b0 = $urandom;
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_grant: gnt0=%b expected 1", gnt0);
    end
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    req0 = 1; req1 = 1; funct0 = 6'h3F; funct1 = 6'h3F;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, unit_start, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1,
         unit_op, unit_a, unit_b, rsp_data0, rsp_data1} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: busy=%b start=%b g=%b%b rv=%b%b a=%h b=%h expected all zero",
               busy, unit_start, gnt0, gnt1, rsp_valid0, rsp_valid1, unit_a, unit_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    last_lane = 1;
    n_checks++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_first_tie: gnt1,gnt0=%b expected 01", {gnt1, gnt0});
    end
    last_lane = 0;
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid0, rsp_valid1, rsp_data0, rsp_err0} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_rsp: rv0=%b rv1=%b d0=%h e0=%b expected 1 0 0 0",
               rsp_valid0, rsp_valid1, rsp_data0, rsp_err0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({busy, rsp_valid0, rsp_valid1} !== 3'b0) begin
      n_fail++;
      $display("FAIL rmid_idle: busy,rv0,rv1=%b expected 000", {busy, rsp_valid0, rsp_valid1});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_invalid();
    test_flush();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000ns, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
